// File: rtl/machine_pkg.sv
// Shared constants for the machine_memctrl pushbutton-driven RAM controller:
// FSM state encoding, command bit indices and default geometry.
package machine_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;
  localparam int NUM_BTN        = 4;

  // Bit positions of the command pulses coming out of the button front end.
  localparam int CMD_LOAD  = 0;
  localparam int CMD_WRITE = 1;
  localparam int CMD_READ  = 2;
  localparam int CMD_CLEAR = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ_WAIT = 2'd1;
  localparam logic [1:0] S_CLEAR     = 2'd2;

endpackage

// File: rtl/machine_btn_edge.sv
// Two-flop synchroniser plus registered rising-edge detector per button bit;
// a held input yields exactly one single-cycle pulse.
module machine_btn_edge
  import machine_pkg::*;
#(
  parameter int WIDTH = NUM_BTN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_pulse
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sync2_d;
  logic [WIDTH-1:0] r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync2_d <= '0;
      r_pulse   <= '0;
    end else begin
      r_sync1   <= i_async;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      // Registered so the pulse is glitch-free and lands on the third edge.
      r_pulse   <= r_sync2 & ~r_sync2_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/machine_memctrl.sv
// Pushbutton RAM controller: load pointer, write-and-increment, registered read
// and a one-word-per-cycle clear sweep over a single-port synchronous RAM.
module machine_memctrl
  import machine_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [DATA_W-1:0] sw,
  input  logic [3:0]        btn,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] led_addr,
  output logic              busy,
  output state_t            o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [3:0]        w_cmd;
  logic              w_idle;
  logic              w_in_clear;
  logic              w_do_clear;
  logic              w_do_write;
  logic              w_do_load;
  logic              w_do_read;
  logic [ADDR_W-1:0] w_sw_addr;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_wdata;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_mem [DEPTH];

  machine_btn_edge #(
    .WIDTH (4)
  ) u_btn_edge (
    .i_clk   (system1000),
    .i_rst_n (system1000_rstn),
    .i_async (btn),
    .o_pulse (w_cmd)
  );

  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign w_sw_addr = sw[ADDR_W-1:0];
    end else begin : g_addr_zext
      assign w_sw_addr = {{(ADDR_W-DATA_W){1'b0}}, sw};
    end
  endgenerate

  // Commands only act in IDLE; one winner, priority clear > write > load > read.
  assign w_idle     = (r_state == S_IDLE);
  assign w_in_clear = (r_state == S_CLEAR);
  assign w_do_clear = w_idle & w_cmd[CMD_CLEAR];
  assign w_do_write = w_idle & ~w_cmd[CMD_CLEAR] & w_cmd[CMD_WRITE];
  assign w_do_load  = w_idle & ~w_cmd[CMD_CLEAR] & ~w_cmd[CMD_WRITE] & w_cmd[CMD_LOAD];
  assign w_do_read  = w_idle & ~w_cmd[CMD_CLEAR] & ~w_cmd[CMD_WRITE] & ~w_cmd[CMD_LOAD]
                    & w_cmd[CMD_READ];

  assign w_ram_addr  = w_in_clear ? r_clr_cnt : r_ptr;
  assign w_ram_we    = w_do_write | w_in_clear;
  assign w_ram_wdata = w_in_clear ? '0 : sw;

  // Single port, read-before-write; contents deliberately survive reset.
  always_ff @(posedge system1000) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
    r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_clr_cnt  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_do_clear) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end else if (w_do_write) begin
            r_ptr <= r_ptr + 1'b1;
          end else if (w_do_load) begin
            r_ptr <= w_sw_addr;
          end else if (w_do_read) begin
            r_state <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          // r_ram_q holds RAM[ptr] captured at the end of the command cycle.
          r_rd_data  <= r_ram_q;
          r_rd_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_CLEAR: begin
          if (&r_clr_cnt) begin
            r_clr_cnt <= '0;
            r_ptr     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // rd_valid is a one-cycle strobe marking the cycle rd_data first shows a new
  // read result; there is no back-pressure, the consumer must take it then.
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign led_addr    = r_ptr;
  assign busy        = w_in_clear;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_machine_memctrl.sv
// Self-checking bench for machine_memctrl: an 8-bit-address and a 10-bit-address
// instance driven through their pushbuttons and compared with a behavioural model.
module tb_machine_memctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic [7:0] sw8, sw10;
  logic [3:0] btn8, btn10;
  logic [7:0] rd_data8, rd_data10;
  logic       rd_valid8, rd_valid10;
  logic [7:0] led8;
  logic [9:0] led10;
  logic       busy8, busy10;
  logic [1:0] dbg8, dbg10;

  machine_memctrl #(.ADDR_W(8), .DATA_W(8)) u_dut8 (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .sw              (sw8),
    .btn             (btn8),
    .rd_data         (rd_data8),
    .rd_valid        (rd_valid8),
    .led_addr        (led8),
    .busy            (busy8),
    .o_dbg_state     (dbg8)
  );

  machine_memctrl #(.ADDR_W(10), .DATA_W(8)) u_dut10 (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .sw              (sw10),
    .btn             (btn10),
    .rd_data         (rd_data10),
    .rd_valid        (rd_valid10),
    .led_addr        (led10),
    .busy            (busy10),
    .o_dbg_state     (dbg10)
  );

  // ---------------- monitor ----------------
  logic [7:0] rd8_q[$], rd10_q[$];
  int         rdc8_q[$], rdc10_q[$];
  int         busy_cnt8 = 0, busy_cnt10 = 0;

  always @(negedge clk) begin
    if (rd_valid8)  begin rd8_q.push_back(rd_data8);   rdc8_q.push_back(cyc);  end
    if (rd_valid10) begin rd10_q.push_back(rd_data10); rdc10_q.push_back(cyc); end
    if (busy8)  busy_cnt8  <= busy_cnt8 + 1;
    if (busy10) busy_cnt10 <= busy_cnt10 + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_mem8 [256];
  logic [7:0] m_mem10 [1024];
  int         m_ptr8, m_ptr10;
  logic [7:0] m_last8;
  logic [7:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  // Press the buttons b with switches s, hold 4 cycles, release for 3.
  // t0 is the cycle count just before the first sampling edge.
  task automatic press(input int which, input logic [3:0] b, input logic [7:0] s,
                       output int t0);
    @(negedge clk);
    if (which == 0) begin sw8 = s; btn8 = b; end
    else begin sw10 = s; btn10 = b; end
    t0 = cyc;
    repeat (4) @(negedge clk);
    if (which == 0) btn8 = 4'h0; else btn10 = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drv_load(input int which, input logic [7:0] s);
    int t0;
    press(which, 4'b0001, s, t0);
    if (which == 0) m_ptr8 = int'(s); else m_ptr10 = int'(s);
  endtask

  task automatic drv_write(input int which, input logic [7:0] s);
    int t0;
    press(which, 4'b0010, s, t0);
    if (which == 0) begin m_mem8[m_ptr8] = s; m_ptr8 = (m_ptr8 + 1) % 256; end
    else begin m_mem10[m_ptr10] = s; m_ptr10 = (m_ptr10 + 1) % 1024; end
  endtask

  // Optionally load addr, then read; returns observed data, latency and pulse count.
  task automatic do_read(input int which, input bit load_first, input int addr,
                         output logic [7:0] d, output int lat, output int n);
    int t0, base;
    logic [7:0] a8;
    a8 = 8'(addr);
    if (load_first) drv_load(which, a8);
    base = (which == 0) ? rd8_q.size() : rd10_q.size();
    press(which, 4'b0100, 8'h00, t0);
    d = 8'hxx;
    lat = -1;
    if (which == 0) begin
      n = rd8_q.size() - base;
      if (n > 0) begin d = rd8_q[base]; lat = rdc8_q[base] - t0; end
    end else begin
      n = rd10_q.size() - base;
      if (n > 0) begin d = rd10_q[base]; lat = rdc10_q[base] - t0; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; sw8 = 8'h42; btn8 = 4'b0001; sw10 = 8'h00; btn10 = 4'h0;
    repeat (3) @(negedge clk);
    if ({rd_data8, rd_valid8, led8, busy8} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs8: got %h expected 0", {rd_data8, rd_valid8, led8, busy8});
    end
    checks++;
    if ({rd_data10, rd_valid10, led10, busy10} !== 20'h0) begin
      errors++; $display("FAIL reset_outputs10: got %h expected 0", {rd_data10, rd_valid10, led10, busy10});
    end
    checks++;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    // Load held through reset release takes effect once.
    if (led8 !== 8'h42) begin
      errors++; $display("FAIL held_btn_load: led_addr=%h expected 42", led8);
    end
    checks++;
    btn8 = 4'h0;
    repeat (3) @(negedge clk);
    if (rd8_q.size() != 0) begin
      errors++; $display("FAIL reset_no_read: rd_valid pulses=%0d expected 0", rd8_q.size());
    end
    checks++;
    m_ptr8 = 8'h42; m_ptr10 = 0; m_last8 = 8'h00;
  endtask

  task automatic test_load_write_read();
    logic [7:0] d; int lat, n;
    drv_load(0, 8'h05);
    if (led8 !== 8'h05) begin errors++; $display("FAIL load_ptr: led_addr=%h expected 05", led8); end
    checks++;
    drv_write(0, 8'hA7);
    if (led8 !== 8'h06) begin errors++; $display("FAIL write_incr: led_addr=%h expected 06", led8); end
    checks++;
    do_read(0, 1'b1, 5, d, lat, n);
    if (n != 1) begin errors++; $display("FAIL read_pulse_count: got %0d expected 1", n); end
    checks++;
    if (d !== 8'hA7) begin errors++; $display("FAIL read_data: got %h expected a7", d); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL read_latency: rd_valid at +%0d expected +5", lat); end
    checks++;
    if (led8 !== 8'h05) begin errors++; $display("FAIL read_ptr_kept: led_addr=%h expected 05", led8); end
    checks++;
    repeat (5) @(negedge clk);
    if (rd_data8 !== 8'hA7 || rd_valid8 !== 1'b0) begin
      errors++; $display("FAIL rd_data_hold: rd_data=%h rd_valid=%b expected a7/0", rd_data8, rd_valid8);
    end
    checks++;
    m_last8 = 8'hA7;
  endtask

  task automatic test_wrap();
    logic [7:0] d; int lat, n;
    drv_load(0, 8'hFF);
    drv_write(0, 8'h3C);
    if (led8 !== 8'h00) begin errors++; $display("FAIL ptr_wrap: led_addr=%h expected 00", led8); end
    checks++;
    do_read(0, 1'b1, 8'hFF, d, lat, n);
    if (n != 1 || d !== 8'h3C) begin
      errors++; $display("FAIL wrap_readback: got %h (pulses %0d) expected 3c", d, n);
    end
    checks++;
    m_last8 = 8'h3C;
  endtask

  task automatic test_priority();
    logic [7:0] d; int lat, n, base, t0;
    drv_load(0, 8'h10);
    base = rd8_q.size();
    press(0, 4'b0110, 8'h9E, t0);
    m_mem8[m_ptr8] = 8'h9E; m_ptr8 = (m_ptr8 + 1) % 256;
    if (rd8_q.size() != base) begin
      errors++; $display("FAIL prio_no_read: rd_valid pulses=%0d expected 0", rd8_q.size() - base);
    end
    checks++;
    if (led8 !== 8'h11) begin errors++; $display("FAIL prio_write_ptr: led_addr=%h expected 11", led8); end
    checks++;
    do_read(0, 1'b1, 8'h10, d, lat, n);
    if (d !== 8'h9E) begin errors++; $display("FAIL prio_write_data: got %h expected 9e", d); end
    checks++;
    m_last8 = 8'h9E;
  endtask

  task automatic test_clear();
    logic [7:0] d; int lat, n, base, bc0, t0;
    drv_load(0, 8'h00);
    drv_write(0, 8'h11); drv_write(0, 8'h22); drv_write(0, 8'h33); drv_write(0, 8'h44);
    bc0 = busy_cnt8;
    base = rd8_q.size();
    press(0, 4'b1000, 8'h00, t0);
    // Commands issued mid-sweep must all be dropped.
    press(0, 4'b0010, 8'h77, t0);
    press(0, 4'b0100, 8'h00, t0);
    press(0, 4'b0001, 8'h55, t0);
    for (int k = 0; k < 2000 && busy8; k++) @(negedge clk);
    if (busy8 !== 1'b0) begin errors++; $display("FAIL clear_timeout: busy still %b", busy8); end
    checks++;
    repeat (2) @(negedge clk);
    if (busy_cnt8 - bc0 != 256) begin
      errors++; $display("FAIL clear_busy_len: got %0d cycles expected 256", busy_cnt8 - bc0);
    end
    checks++;
    if (rd8_q.size() != base) begin
      errors++; $display("FAIL clear_ignored_read: rd_valid pulses=%0d expected 0", rd8_q.size() - base);
    end
    checks++;
    if (led8 !== 8'h00) begin errors++; $display("FAIL clear_ptr: led_addr=%h expected 00", led8); end
    checks++;
    for (int a = 0; a < 256; a++) m_mem8[a] = 8'h00;
    m_ptr8 = 0;
    for (int a = 0; a < 256; a++) begin
      do_read(0, 1'b1, a, d, lat, n);
      if (n != 1 || d !== m_mem8[a]) begin
        errors++; $display("FAIL clear_word[%0d]: got %h (pulses %0d) expected %h", a, d, n, m_mem8[a]);
      end
      checks++;
    end
    m_last8 = 8'h00;
  endtask

  task automatic test_random();
    logic [3:0] b; logic [7:0] s, got; int t0, base, nexp;
    for (int i = 0; i < 60; i++) begin
      b = 4'($urandom_range(1, 7));
      s = 8'($urandom_range(0, 255));
      nexp = 0;
      if (b[1]) begin m_mem8[m_ptr8] = s; m_ptr8 = (m_ptr8 + 1) % 256; end
      else if (b[0]) m_ptr8 = int'(s);
      else if (b[2]) begin exp_q.push_back(m_mem8[m_ptr8]); m_last8 = m_mem8[m_ptr8]; nexp = 1; end
      base = rd8_q.size();
      press(0, b, s, t0);
      if (rd8_q.size() - base != nexp) begin
        errors++; $display("FAIL rand_pulses[%0d] btn=%b: got %0d expected %0d", i, b, rd8_q.size() - base, nexp);
      end
      checks++;
      if (nexp == 1 && exp_q.size() > 0) begin
        got = (rd8_q.size() > base) ? rd8_q[base] : 8'hxx;
        if (got !== exp_q[0]) begin
          errors++; $display("FAIL rand_read[%0d]: got %h expected %h", i, got, exp_q[0]);
        end
        checks++;
        void'(exp_q.pop_front());
      end
      if (led8 !== 8'(m_ptr8) || rd_data8 !== m_last8) begin
        errors++; $display("FAIL rand_state[%0d] btn=%b: led=%h rd_data=%h expected %h/%h",
                           i, b, led8, rd_data8, 8'(m_ptr8), m_last8);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] d; int lat, n, t0;
    drv_load(0, 8'd97);
    drv_write(0, 8'hA1); drv_write(0, 8'hA2); drv_write(0, 8'hA3); drv_write(0, 8'hA4);
    drv_load(0, 8'd200);
    drv_write(0, 8'hC8);
    @(negedge clk);
    btn8 = 4'b1000;
    t0 = cyc;
    repeat (4) @(negedge clk);
    btn8 = 4'h0;
    // Stop after exactly 100 words (addresses 0..99) have been cleared.
    for (int k = 0; k < 300 && cyc < t0 + 104; k++) @(negedge clk);
    if (busy8 !== 1'b1) begin errors++; $display("FAIL midclear_busy: busy=%b expected 1", busy8); end
    checks++;
    rstn = 1'b0;
    #1;
    if ({rd_data8, rd_valid8, led8, busy8} !== 18'h0) begin
      errors++; $display("FAIL midclear_reset_outputs: got %h expected 0", {rd_data8, rd_valid8, led8, busy8});
    end
    checks++;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int a = 0; a < 100; a++) m_mem8[a] = 8'h00;
    m_ptr8 = 0; m_ptr10 = 0; m_last8 = 8'h00;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 101; a++) begin
      do_read(0, 1'b1, a, d, lat, n);
      if (d !== m_mem8[a]) begin
        errors++; $display("FAIL midclear_word[%0d]: got %h expected %h", a, d, m_mem8[a]);
      end
      checks++;
    end
    do_read(0, 1'b1, 200, d, lat, n);
    if (d !== 8'hC8) begin errors++; $display("FAIL midclear_word[200]: got %h expected c8", d); end
    checks++;
  endtask

  task automatic test_param_sweep();
    logic [7:0] d; int lat, n, bc0, t0;
    drv_load(1, 8'hFF);
    if (led10 !== 10'h0FF) begin errors++; $display("FAIL p10_load_zext: led_addr=%h expected 0ff", led10); end
    checks++;
    for (int i = 0; i < 768; i++) drv_write(1, 8'($urandom_range(0, 255)));
    if (led10 !== 10'h3FF) begin errors++; $display("FAIL p10_walk: led_addr=%h expected 3ff", led10); end
    checks++;
    drv_write(1, 8'h5A);
    if (led10 !== 10'h000) begin errors++; $display("FAIL p10_wrap: led_addr=%h expected 000", led10); end
    checks++;
    for (int i = 0; i < 1023; i++) drv_write(1, 8'($urandom_range(0, 255)));
    do_read(1, 1'b0, 0, d, lat, n);
    if (n != 1 || d !== m_mem10[1023] || lat != 5) begin
      errors++; $display("FAIL p10_read_3ff: got %h (pulses %0d, lat %0d) expected %h", d, n, lat, m_mem10[1023]);
    end
    checks++;
    do_read(1, 1'b1, 8'h80, d, lat, n);
    if (d !== m_mem10[128]) begin errors++; $display("FAIL p10_read_080: got %h expected %h", d, m_mem10[128]); end
    checks++;
    bc0 = busy_cnt10;
    press(1, 4'b1000, 8'h00, t0);
    for (int k = 0; k < 3000 && busy10; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (busy_cnt10 - bc0 != 1024) begin
      errors++; $display("FAIL p10_busy_len: got %0d cycles expected 1024", busy_cnt10 - bc0);
    end
    checks++;
    if (led10 !== 10'h000) begin errors++; $display("FAIL p10_clear_ptr: led_addr=%h expected 000", led10); end
    checks++;
    do_read(1, 1'b1, 8'hFF, d, lat, n);
    if (d !== 8'h00) begin errors++; $display("FAIL p10_clear_word: got %h expected 00", d); end
    checks++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int a = 0; a < 256; a++) m_mem8[a] = 8'h00;
    for (int a = 0; a < 1024; a++) m_mem10[a] = 8'h00;
    test_reset();
    test_load_write_read();
    test_wrap();
    test_priority();
    test_clear();
    test_random();
    test_reset_mid_clear();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/machine_memctrl.md
MACHINE_MEMCTRL -- requirements
Module: machine_memctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, RAM address width; depth = 2^ADDR_W words.
REQ-002 Parameter: DATA_W, default 8, RAM word width and switch-bank width.
REQ-003 Port: system1000  in  1  clock; all state updates on rising edge.
REQ-004 Port: system1000_rstn  in  1  reset, asynchronous, active-low.
REQ-005 Port: sw  in  DATA_W  switch bank; write data and address-load source.
REQ-006 Port: btn  in  4  asynchronous pushbuttons: [0] load ptr, [1] write, [2] read, [3] clear.
REQ-007 Port: rd_data  out  DATA_W  last word read, registered.
REQ-008 Port: rd_valid  out  1  one-cycle pulse when rd_data is updated.
REQ-009 Port: led_addr  out  ADDR_W  current pointer value.
REQ-010 Port: busy  out  1  high while the clear sweep runs.

Function
REQ-011 Each btn bit SHALL pass through a 2-FF synchroniser, then a rising-edge detector producing a one-cycle command pulse.
REQ-012 The command cycle C is the cycle in which a command pulse is high; the pulse rises 3 clock edges after btn is first sampled high, and a held button SHALL generate exactly one pulse.
REQ-013 The FSM SHALL have exactly three states: IDLE, READ_WAIT and CLEAR.
REQ-014 Pulses arriving while the FSM is not in IDLE SHALL be discarded.
REQ-015 When several pulses coincide in IDLE, priority is clear > write > load > read; only the winner executes and the rest are discarded.
REQ-016 Load: ptr <= sw at end of C, truncated to the low ADDR_W bits if ADDR_W <= DATA_W, else zero-extended; the FSM stays in IDLE.
REQ-017 Write: RAM[ptr] <= sw at end of C, then ptr <= ptr+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0); the FSM stays in IDLE.
REQ-018 Read: the RAM is addressed with ptr in C, and the FSM goes IDLE -> READ_WAIT.
REQ-019 Read (continued): rd_data is loaded at end of C+1, rd_valid is high for cycle C+2 only, the FSM returns to IDLE at end of C+1, and ptr is unchanged.
REQ-020 Clear: the FSM goes IDLE -> CLEAR, and busy is high from C+1 for exactly 2^ADDR_W cycles.
REQ-021 Clear (continued): one word per cycle is written with 0 at addresses 0 .. 2^ADDR_W-1 ascending; on the final write, ptr <= 0 and the FSM returns to IDLE.
REQ-022 RAM SHALL be single-port synchronous, with a 1-cycle read; a read of a word written in the same cycle returns the old data.
REQ-023 rd_data SHALL hold its value between reads.
REQ-024 led_addr SHALL equal ptr combinationally.

Reset
REQ-025 On reset assertion the following SHALL clear to 0 immediately: ptr, rd_data, rd_valid, busy, synchroniser FFs, edge-detect FFs and the clear counter; the FSM goes to IDLE.
REQ-026 Reset during CLEAR SHALL abort the sweep, leaving words already cleared at 0 and the rest unchanged.
REQ-027 RAM contents SHALL NOT be reset; they are initialised to all zeros at configuration.
REQ-028 A button held through reset release SHALL produce one command after synchronisation.

Structure
REQ-029 Shared package machine_pkg SHALL hold the FSM state encoding, the command index constants (LOAD=0, WRITE=1, READ=2, CLEAR=3) and the default ADDR_W/DATA_W values.
REQ-030 Synchroniser and edge detect SHALL be one sub-module, machine_btn_edge, parametrised by width and instantiated once with width 4.
REQ-031 The RAM SHALL be inferred inline, with no vendor primitive.

Verification
REQ-032 Load/write/read: sw=0x05 + btn[0]; then sw=0xA7 + btn[1] -> RAM[5]=0xA7 and led_addr=6; then btn[0] with sw=0x05, then btn[2] -> rd_data=0xA7 with rd_valid one cycle at C+2.
REQ-033 Wrap: load ptr=0xFF, write 0x3C -> led_addr=0x00; read at ptr 0xFF -> 0x3C.
REQ-034 Clear: fill addresses 0..3 with nonzero values, then btn[3] -> busy high exactly 256 cycles, pulses injected during busy are ignored, reads of 0..255 return 0, and led_addr=0 afterwards.
REQ-035 Priority: btn[1] and btn[2] rise together -> only the write occurs, with no rd_valid.
REQ-036 Reset mid-clear: assert reset at busy cycle 100 -> outputs are 0 immediately, addresses 0..99 read 0, and address 200 retains its prior value.
REQ-037 Parameter sweep: with ADDR_W=10, DATA_W=8, loading sw=0xFF gives led_addr=0x0FF; write/read back at 0x3FF; clear makes busy 1024 cycles.
